uart_rx_ctrl: RTL and testbench

Receive controller for the UART RX path. Oversamples the asynchronous `rx` line, detects and qualifies start bits, and drives the serial-in/parallel-out frame shift register with one `shift_d`/`shift_en` pair per bit at bit centre. After the 11th bit it reads the shifter's parallel word back, extracts the data byte, checks even parity and the stop bit, and presents the result to the consumer.

---
 rtl/uart_rx_ctrl.sv | 138 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Function : UART receive controller. Synchronises and oversamples rx,
//            qualifies start bits, strobes an external frame shift register
//            once per bit at bit centre, then decodes the completed frame
//            (data byte, even parity, stop bit) for the consumer.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int BAUD_DIV    = 5208,
  parameter int WORD_LENGTH = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  input  logic [WORD_LENGTH-1:0] frame_q,
  output logic                   shift_en,
  output logic                   shift_d,
  output logic                   busy,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  output logic                   parity_err,
  output logic                   framing_err
);

  localparam int             CW      = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]  HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [3:0]     LAST    = 4'(WORD_LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   bcnt;
  logic [3:0]      nbit;
  logic            rx_m;
  logic            rx_s;
  logic            armed;
  logic            sample_pt;

  // The start-bit position of the readback is 0 by construction; it carries
  // no information for the decode.
  logic            unused_start;
  assign unused_start = frame_q[WORD_LENGTH-1];

  // Two-flop synchronizer; idles high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // The strobe is decoded from the state so the shifter captures in the very
  // cycle the bit is sampled; a high start sample is a glitch and is not shifted.
  assign sample_pt = ((state == START) && (bcnt == HALF_M1)) ||
                     ((state == DATA)  && (bcnt == FULL_M1));
  assign shift_en  = sample_pt && !((state == START) && rx_s);
  assign shift_d   = shift_en & rx_s;

  // Receive FSM: start qualification, bit timing, and frame decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bcnt        <= '0;
      nbit        <= 4'd0;
      armed       <= 1'b0;
      busy        <= 1'b0;
      rx_valid    <= 1'b0;
      rx_data     <= 8'h00;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // A falling edge needs a preceding high sample, so a held-low line
      // (break) never re-triggers until it has returned high.
      armed    <= rx_s;
      case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            bcnt  <= '0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (bcnt == HALF_M1) begin
            bcnt <= '0;
            if (rx_s) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              nbit  <= 4'd1;
              state <= DATA;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        DATA: begin
          if (bcnt == FULL_M1) begin
            bcnt <= '0;
            nbit <= nbit + 4'd1;
            if (nbit == LAST) begin
              state <= DONE;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        DONE: begin
          // Data sits MSB-side in the shifter with d0 oldest, so reverse it.
          for (int i = 0; i < 8; i++) begin
            rx_data[i] <= frame_q[WORD_LENGTH-2-i];
          end
          parity_err  <= ^frame_q[WORD_LENGTH-2:1];
          framing_err <= ~frame_q[0];
          rx_valid    <= 1'b1;
          busy        <= 1'b0;
          nbit        <= 4'd0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Function : Scoreboard bench for uart_rx_ctrl with the frame shift register
//            modelled alongside. Stimulus pushes expected frames; a monitor
//            pops and compares on every rx_valid and checks strobe timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int BD = 16;

  logic        clk;
  logic        reset;
  logic        rx;
  logic [10:0] frame_q;
  logic        shift_en;
  logic        shift_d;
  logic        busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        parity_err;
  logic        framing_err;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];

  int checks      = 0;
  int errors      = 0;
  int cyc         = 0;
  int start_cyc   = 0;
  int last_se     = 0;
  int se_cnt      = 0;
  int shift_total = 0;
  int nvalid      = 0;
  bit prev_valid  = 1'b0;

  uart_rx_ctrl #(
    .BAUD_DIV   (BD),
    .WORD_LENGTH(11)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .frame_q    (frame_q),
    .shift_en   (shift_en),
    .shift_d    (shift_d),
    .busy       (busy),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .framing_err(framing_err)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame shift register: shifts left, new bit enters at [0]
  always @(posedge clk or posedge reset) begin
    if (reset) frame_q <= 11'd0;
    else if (shift_en) frame_q <= {frame_q[9:0], shift_d};
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: strobe timing plus scoreboard pop on every rx_valid
  always @(negedge clk) begin
    if (reset) begin
      se_cnt     = 0;
      prev_valid = 1'b0;
    end else begin
      if (shift_en) begin
        if (se_cnt == 0) chk("first_shift_latency", cyc - start_cyc, 2 + BD / 2);
        else             chk("shift_spacing", cyc - last_se, BD);
        last_se = cyc;
        se_cnt++;
        shift_total++;
      end
      if (rx_valid) begin
        exp_t e;
        nvalid++;
        chk("shift_count", se_cnt, 11);
        chk("valid_width", int'(prev_valid), 0);
        chk("busy_low_at_valid", int'(busy), 0);
        se_cnt = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", int'(rx_data), int'(e.d));
          chk("parity_err", int'(parity_err), int'(e.pe));
          chk("framing_err", int'(framing_err), int'(e.fe));
        end
      end
      prev_valid = rx_valid;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends start, d0..d7, parity, stop; pushes the hand-computed expectation.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input logic [7:0] ed, input logic epe, input logic efe);
    logic [10:0] bits;
    exp_t e;
    bits = {s, p, d, 1'b0};
    e.d  = ed;
    e.pe = epe;
    e.fe = efe;
    exp_q.push_back(e);
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      if (i == 0) start_cyc = cyc;
      repeat (BD) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int busy_hits;
    int base;
    logic [10:0] pbits;

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        int'({shift_en, shift_d, busy, rx_valid, parity_err, framing_err, rx_data}), 0);
    reset = 1'b0;
    idle(4);

    // Good frame
    send_frame(8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    idle(4);

    // Bad parity
    send_frame(8'hA3, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0);
    idle(4);

    // Reset during data bit 4 of an abandoned frame
    pbits = {1'b1, 1'b0, 8'h96, 1'b0};
    for (int i = 0; i < 6; i++) begin
      rx = pbits[i];
      if (i == 0) start_cyc = cyc;
      repeat ((i == 5) ? BD / 2 : BD) @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("midframe_reset_outputs",
        int'({shift_en, shift_d, busy, rx_valid, parity_err, framing_err, rx_data}), 0);
    repeat (3) @(posedge clk);
    #1;
    rx    = 1'b1;
    reset = 1'b0;
    idle(4);
    send_frame(8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    idle(4);

    // Bad stop bit followed by a held-low line
    send_frame(8'h0F, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1);
    rx = 1'b0;
    busy_hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_hits++;
    end
    chk("break_no_busy", busy_hits, 0);
    @(posedge clk);
    #1;
    idle(20);
    chk("break_release_no_busy", int'(busy), 0);

    // Glitch shorter than half a bit
    base = shift_total;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("glitch_busy_seen", int'(busy), 1);
    repeat (8) @(posedge clk);
    #1;
    chk("glitch_busy_dropped", int'(busy), 0);
    chk("glitch_no_shift", shift_total - base, 0);
    idle(10);

    // Back-to-back frames
    send_frame(8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    send_frame(8'hFE, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    idle(40);

    chk("pending_expected", exp_q.size(), 0);
    chk("valid_count", nvalid, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
